noc_switch_allocator: RTL and testbench

Per-output round-robin switch allocator for the 5-port mesh router. It consumes the one-hot route per input port produced by the direction decoder and locks each output port to one input for a whole wormhole packet (head to tail). It drives the crossbar select/grant matrix. It sits between the per-input route-compute stage and the crossbar/output buffers.

---
 rtl/noc_switch_allocator.sv | 164 ++++++++++++++++
 tb/tb_noc_switch_allocator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/noc_switch_allocator.sv
// Switch allocator for the 5-port mesh router. Each output arbitrates round-robin
// and stays locked to one input from a packet's head flit until its tail is granted.
module noc_sa_out #(
    parameter int NPORT = 5,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NPORT-1:0] cand,
    input  logic             out_ready,
    input  logic [NPORT-1:0] req_valid,
    input  logic [NPORT-1:0] req_tail,
    output logic [NPORT-1:0] grant,
    output logic             busy,
    output logic [PTR_W-1:0] owner
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win, idx;
    logic [PTR_W:0]   sum;
    logic             found;
    logic             fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // First candidate at or after the pointer, wrapping NPORT-1 -> 0.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NPORT; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NPORT))
                sum = sum - (PTR_W+1)'(NPORT);
            idx = sum[PTR_W-1:0];
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant   = '0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCKED;
                    owner_d = win;
                    ptr_d   = (win == PTR_W'(NPORT-1)) ? '0 : win + 1'b1;
                end
            end
            LOCKED: begin
                fire           = out_ready & req_valid[owner_q];
                grant[owner_q] = fire;
                if (fire && req_tail[owner_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == LOCKED);
    assign owner = owner_q;
endmodule

module noc_switch_allocator #(
    parameter int NPORT = 5,
    parameter int PTR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPORT-1:0]       req_valid_i,
    input  logic [NPORT*NPORT-1:0] req_dir_i,
    input  logic [NPORT-1:0]       req_tail_i,
    input  logic [NPORT-1:0]       out_ready_i,
    output logic [NPORT*NPORT-1:0] grant_o,
    output logic [NPORT-1:0]       in_grant_o,
    output logic [NPORT-1:0]       out_busy_o,
    output logic [NPORT-1:0]       dir_err_o
);
    logic [NPORT-1:0]            onehot;
    logic [NPORT-1:0]            owned;
    logic [NPORT-1:0][NPORT-1:0] cand;
    logic [NPORT-1:0][NPORT-1:0] row;
    logic [NPORT-1:0][PTR_W-1:0] owner;
    logic [NPORT-1:0]            d;

    always_comb begin
        onehot = '0;
        d      = '0;
        for (int i = 0; i < NPORT; i++) begin
            d         = req_dir_i[i*NPORT +: NPORT];
            onehot[i] = (d != '0) && ((d & (d - NPORT'(1))) == '0);
        end
    end

    // An input that already holds an output may not compete for another.
    always_comb begin
        owned = '0;
        for (int o = 0; o < NPORT; o++)
            for (int i = 0; i < NPORT; i++)
                if (out_busy_o[o] && owner[o] == PTR_W'(i))
                    owned[i] = 1'b1;
    end

    always_comb begin
        cand = '0;
        for (int o = 0; o < NPORT; o++)
            for (int i = 0; i < NPORT; i++)
                cand[o][i] = req_valid_i[i] & onehot[i] & req_dir_i[i*NPORT+o] & ~owned[i];
    end

    genvar o;
    generate
        for (o = 0; o < NPORT; o++) begin : g_out
            noc_sa_out #(.NPORT(NPORT), .PTR_W(PTR_W)) u_out (
                .clk       (clk),
                .rst       (rst),
                .cand      (cand[o]),
                .out_ready (out_ready_i[o]),
                .req_valid (req_valid_i),
                .req_tail  (req_tail_i),
                .grant     (row[o]),
                .busy      (out_busy_o[o]),
                .owner     (owner[o])
            );
        end
    endgenerate

    always_comb begin
        grant_o    = '0;
        in_grant_o = '0;
        for (int k = 0; k < NPORT; k++) begin
            grant_o[k*NPORT +: NPORT] = row[k];
            in_grant_o                = in_grant_o | row[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dir_err_o <= '0;
        else
            dir_err_o <= dir_err_o | (req_valid_i & ~onehot);
    end
endmodule

// File: tb/tb_noc_switch_allocator.sv
// Randomized bench for noc_switch_allocator: wormhole packets per input, a
// packet-level reference model, and a queue-based scoreboard checked on negedge.
module tb_noc_switch_allocator;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid_i, req_tail_i, out_ready_i;
    logic [N*N-1:0] req_dir_i;
    logic [N*N-1:0] grant_o;
    logic [N-1:0]   in_grant_o, out_busy_o, dir_err_o;

    noc_switch_allocator #(.NPORT(N), .PTR_W(3)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_dir_i(req_dir_i),
        .req_tail_i(req_tail_i), .out_ready_i(out_ready_i), .grant_o(grant_o),
        .in_grant_o(in_grant_o), .out_busy_o(out_busy_o), .dir_err_o(dir_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*N-1:0] g;
        logic [N-1:0]   ig;
        logic [N-1:0]   busy;
        logic [N-1:0]   err;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // reference model: which input each output serves, and its rotating start point
    bit       m_lock[N];
    int       m_own[N];
    int       m_ptr[N];
    bit [N-1:0] m_err;
    // packet generators
    bit       has[N], isbad[N];
    int       len[N], life[N];
    logic [N-1:0] pd[N];
    int       pg[N];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] dsl(int i);
        return req_dir_i[i*N +: N];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_lock[k] = 0; m_own[k] = 0; m_ptr[k] = 0;
            has[k] = 0; isbad[k] = 0; len[k] = 0; life[k] = 0; pd[k] = '0; pg[k] = -1;
        end
        m_err = '0;
        req_valid_i = '0; req_tail_i = '0; out_ready_i = '0; req_dir_i = '0;
    endtask

    // Apply one clock edge using the inputs driven in the cycle that just ended.
    task automatic model_step();
        bit owned[N];
        int i;
        for (int k = 0; k < N; k++) owned[k] = 0;
        for (int o = 0; o < N; o++) if (m_lock[o]) owned[m_own[o]] = 1;
        for (int o = 0; o < N; o++) begin
            if (m_lock[o]) begin
                if (pg[o] >= 0 && req_tail_i[pg[o]]) m_lock[o] = 0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr[o] + k) % N;
                    if (req_valid_i[i] && $countones(dsl(i)) == 1 && dsl(i)[o] && !owned[i]) begin
                        m_lock[o] = 1; m_own[o] = i; m_ptr[o] = (i + 1) % N;
                        break;
                    end
                end
            end
        end
        for (int k = 0; k < N; k++)
            if (req_valid_i[k] && $countones(dsl(k)) != 1) m_err[k] = 1;
        for (int o = 0; o < N; o++)
            if (pg[o] >= 0) begin
                len[pg[o]]--;
                if (len[pg[o]] == 0) has[pg[o]] = 0;
            end
        for (int k = 0; k < N; k++)
            if (has[k] && isbad[k]) begin
                life[k]--;
                if (life[k] == 0) has[k] = 0;
            end
    endtask

    task automatic drive(int rdy_pct);
        int a, c;
        exp_t e;
        for (int k = 0; k < N; k++) begin
            if (!has[k] && ($urandom % 2 == 0)) begin
                has[k] = 1;
                if ($urandom % 10 == 0) begin
                    isbad[k] = 1;
                    life[k]  = 1 + $urandom % 6;
                    len[k]   = 0;
                    a = $urandom % N;
                    c = (a + 1 + $urandom % (N-1)) % N;
                    pd[k] = ($urandom % 2 == 0) ? '0 : N'((1 << a) | (1 << c));
                end else begin
                    isbad[k] = 0;
                    pd[k]    = N'(1 << ($urandom % N));
                    len[k]   = 1 + $urandom % 4;
                end
            end
            req_valid_i[k] = has[k] && ($urandom % 4 != 0);
            req_tail_i[k]  = isbad[k] ? 1'($urandom % 2) : (len[k] == 1);
            req_dir_i[k*N +: N] = has[k] ? pd[k] : N'($urandom);
        end
        for (int o = 0; o < N; o++) out_ready_i[o] = ($urandom % 100) < rdy_pct;
        e = '0;
        for (int o = 0; o < N; o++) begin
            pg[o] = -1;
            if (m_lock[o] && out_ready_i[o] && req_valid_i[m_own[o]]) begin
                e.g[o*N + m_own[o]] = 1'b1;
                e.ig[m_own[o]]      = 1'b1;
                pg[o]               = m_own[o];
            end
            e.busy[o] = m_lock[o];
        end
        e.err = m_err;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [N-1:0] col;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("grant", 32'(grant_o), 32'(e.g));
            chk("in_grant", 32'(in_grant_o), 32'(e.ig));
            chk("out_busy", 32'(out_busy_o), 32'(e.busy));
            chk("dir_err", 32'(dir_err_o), 32'(e.err));
            for (int o = 0; o < N; o++)
                chk("row_onehot0", 32'($countones(grant_o[o*N +: N]) <= 1), 32'd1);
            for (int i = 0; i < N; i++) begin
                for (int o = 0; o < N; o++) col[o] = grant_o[o*N + i];
                chk("col_onehot0", 32'($countones(col) <= 1), 32'd1);
            end
        end
    end

    initial begin
        bit skip;
        int pct;
        rst = 1'b1;
        model_reset();
        #12;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy", 32'(out_busy_o), 32'd0);
        chk("rst_err", 32'(dir_err_o), 32'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        skip = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!skip) begin
                @(posedge clk); #1;
                model_step();
            end
            skip = 0;
            pct  = (cyc < 1000) ? 90 : (cyc < 2000) ? 40 : 100;
            drive(pct);
            if (cyc == 700 || cyc == 1700 || cyc == 2600) begin
                // asynchronous reset mid-cycle, with packets in flight
                @(negedge clk); #2;
                rst = 1'b1;
                #1;
                chk("arst_grant", 32'(grant_o), 32'd0);
                chk("arst_in_grant", 32'(in_grant_o), 32'd0);
                chk("arst_busy", 32'(out_busy_o), 32'd0);
                chk("arst_err", 32'(dir_err_o), 32'd0);
                model_reset();
                @(posedge clk); #1;
                rst  = 1'b0;
                skip = 1;
            end
        end
        @(negedge clk); #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
